// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous single-port data memory between the
// core load/store path and a host loader/debug port. The core has fixed
// priority. A saturating starvation counter forces a refused host request
// through after STARVE_MAX refusals. host_lock lets the host hold the memory
// for a burst once it has been granted.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          rst_n,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          core_rvalid_q, host_rvalid_q;
    logic [DW-1:0] core_rdata_q, host_rdata_q;

    // Raw grants feed the state registers. The registers are held in reset
    // anyway, so only the externally visible grants need masking by rst_n.
    logic core_gnt_raw, host_gnt_raw;

    // Grant decision: LOCK gives the memory to the host only. In ARB the core
    // wins ties unless the host has already been refused STARVE_MAX times.
    always_comb begin
        core_gnt_raw = 1'b0;
        host_gnt_raw = 1'b0;
        if (state_q == LOCK) begin
            host_gnt_raw = host_req;
        end else if (core_req && host_req) begin
            if (starve_q >= STARVE_LIM) begin
                host_gnt_raw = 1'b1;
            end else begin
                core_gnt_raw = 1'b1;
            end
        end else begin
            core_gnt_raw = core_req;
            host_gnt_raw = host_req;
        end
    end

    // Next-state: the counter grows only while the host is waiting and
    // refused. The lock is entered only on a real host grant.
    always_comb begin
        starve_d = 4'd0;
        if (host_req && !host_gnt_raw) begin
            starve_d = (starve_q >= STARVE_LIM) ? starve_q : starve_q + 4'd1;
        end
        state_d = state_q;
        case (state_q)
            ARB:     if (host_gnt_raw && host_lock) state_d = LOCK;
            LOCK:    if (!host_lock) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Visible grants are forced low during reset. The memory port is muxed
    // from the winner and reads as all zeros when idle.
    always_comb begin
        core_gnt   = core_gnt_raw & rst_n;
        host_gnt   = host_gnt_raw & rst_n;
        core_stall = core_req & ~core_gnt;
        mem_en     = core_gnt | host_gnt;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Arbiter state, read-valid pipeline and read-data holding registers.
    // A reset clears any pending rvalid, so it can never appear after release.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB;
            starve_q      <= 4'd0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            core_rvalid_q <= core_gnt_raw & ~core_we;
            host_rvalid_q <= host_gnt_raw & ~host_we;
            if (core_rvalid_q) core_rdata_q <= mem_rdata;
            if (host_rvalid_q) host_rdata_q <= mem_rdata;
        end
    end

    // The memory returns read data in the rvalid cycle. It is passed straight
    // through then, and the held copy is shown until the next read returns.
    always_comb begin
        core_rvalid = core_rvalid_q;
        host_rvalid = host_rvalid_q;
        core_rdata  = core_rvalid_q ? mem_rdata : core_rdata_q;
        host_rdata  = host_rvalid_q ? mem_rdata : host_rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for the data-memory arbiter, with a
// simple synchronous RAM behind the memory port.
module tb_dmem_arbiter;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] mem [0:255];

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_MAX(4)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM: write at the edge, read data next cycle.
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca,
                         input logic [7:0] cd, input logic hr, input logic hw,
                         input logic [7:0] ha, input logic [7:0] hd,
                         input logic hl);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        host_lock = hl;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h01, 8'h00, 0);
        sample();
        tests++; if (core_gnt !== 1'b0) begin fails++; $display("[TB] FAIL reset_core_gnt got %b want 0", core_gnt); end
        tests++; if (host_gnt !== 1'b0) begin fails++; $display("[TB] FAIL reset_host_gnt got %b want 0", host_gnt); end
        tests++; if (mem_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_en got %b want 0", mem_en); end
        tests++; if (core_stall !== 1'b1) begin fails++; $display("[TB] FAIL reset_core_stall got %b want 1", core_stall); end
        tests++; if ({core_rvalid, host_rvalid} !== 2'b00) begin fails++; $display("[TB] FAIL reset_rvalid got %b want 00", {core_rvalid, host_rvalid}); end
        tests++; if ({core_rdata, host_rdata} !== 16'h0000) begin fails++; $display("[TB] FAIL reset_rdata got %h want 0000", {core_rdata, host_rdata}); end
        tick();
        rst_n = 1'b1;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_host_only();
        tick(); drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h5A, 0); sample();
        tests++; if ({host_gnt, core_gnt, core_stall} !== 3'b100) begin fails++; $display("[TB] FAIL host_wr_gnt got %b want 100", {host_gnt, core_gnt, core_stall}); end
        tests++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h20, 8'h5A}) begin fails++; $display("[TB] FAIL host_wr_mem got %b_%b_%h_%h want 1_1_20_5a", mem_en, mem_we, mem_addr, mem_wdata); end
        tick(); drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0); sample();
        tests++; if ({host_gnt, mem_we, host_rvalid, core_stall} !== 4'b1000) begin fails++; $display("[TB] FAIL host_rd_gnt got %b want 1000", {host_gnt, mem_we, host_rvalid, core_stall}); end
        tick(); drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0); sample();
        tests++; if ({host_rvalid, host_rdata} !== {1'b1, 8'h5A}) begin fails++; $display("[TB] FAIL host_rd_data got %b/%h want 1/5a", host_rvalid, host_rdata); end
        tests++; if ({core_rvalid, mem_en, mem_addr} !== 10'd0) begin fails++; $display("[TB] FAIL host_idle_mem got %b/%b/%h want 0/0/00", core_rvalid, mem_en, mem_addr); end
        tick(); sample();
        tests++; if ({host_rvalid, host_rdata} !== {1'b0, 8'h5A}) begin fails++; $display("[TB] FAIL host_rdata_hold got %b/%h want 0/5a", host_rvalid, host_rdata); end
    endtask

    task automatic test_core_read();
        tick(); drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0); sample();
        tests++; if ({core_gnt, core_stall, mem_addr} !== {2'b10, 8'h10}) begin fails++; $display("[TB] FAIL core_rd_gnt got %b/%b/%h want 1/0/10", core_gnt, core_stall, mem_addr); end
        tick(); drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0); sample();
        tests++; if ({core_rvalid, core_rdata, host_rvalid} !== {1'b1, 8'hC3, 1'b0}) begin fails++; $display("[TB] FAIL core_rd_data got %b/%h/%b want 1/c3/0", core_rvalid, core_rdata, host_rvalid); end
        tick(); sample();
        tests++; if ({core_rvalid, core_rdata} !== {1'b0, 8'hC3}) begin fails++; $display("[TB] FAIL core_rdata_hold got %b/%h want 0/c3", core_rvalid, core_rdata); end
    endtask

    task automatic test_contention();
        logic hexp;
        for (int i = 0; i < 10; i++) begin
            tick(); drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h02, 8'h00, 0); sample();
            hexp = (i % 5 == 4);
            tests++; if ({core_gnt, host_gnt, core_stall} !== {~hexp, hexp, hexp}) begin fails++; $display("[TB] FAIL contention_c%0d got %b want %b", i, {core_gnt, host_gnt, core_stall}, {~hexp, hexp, hexp}); end
            if (i == 5) begin
                tests++; if ({host_rvalid, host_rdata, core_rvalid} !== {1'b1, 8'hA2, 1'b0}) begin fails++; $display("[TB] FAIL contention_rvalid got %b/%h/%b want 1/a2/0", host_rvalid, host_rdata, core_rvalid); end
            end
            if (i == 6) begin
                tests++; if ({core_rvalid, core_rdata, host_rvalid} !== {1'b1, 8'hC3, 1'b0}) begin fails++; $display("[TB] FAIL contention_core_back got %b/%h/%b want 1/c3/0", core_rvalid, core_rdata, host_rvalid); end
            end
        end
        tick(); drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_lock_burst();
        logic [7:0] exp_data [0:3];
        exp_data[0] = 8'hA0; exp_data[1] = 8'hA1; exp_data[2] = 8'hA2; exp_data[3] = 8'hA3;
        tick(); drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1); sample();
        tests++; if ({host_gnt, core_gnt} !== 2'b10) begin fails++; $display("[TB] FAIL lock_enter got %b want 10", {host_gnt, core_gnt}); end
        for (int k = 1; k < 4; k++) begin
            tick(); drive(1, 0, 8'h10, 8'h00, 1, 0, 8'(k), 8'h00, 1); sample();
            tests++; if ({core_gnt, core_stall, host_gnt} !== 3'b011) begin fails++; $display("[TB] FAIL lock_burst_c%0d got %b want 011", k, {core_gnt, core_stall, host_gnt}); end
            tests++; if ({host_rvalid, host_rdata} !== {1'b1, exp_data[k-1]}) begin fails++; $display("[TB] FAIL lock_data_c%0d got %b/%h want 1/%h", k, host_rvalid, host_rdata, exp_data[k-1]); end
        end
        tick(); drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1); sample();
        tests++; if ({core_gnt, core_stall, host_rvalid, host_rdata} !== {3'b011, 8'hA3}) begin fails++; $display("[TB] FAIL lock_hold got %b/%b/%b/%h want 0/1/1/a3", core_gnt, core_stall, host_rvalid, host_rdata); end
        tick(); drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0); sample();
        tests++; if ({core_gnt, core_stall, host_rvalid} !== 3'b010) begin fails++; $display("[TB] FAIL lock_drop got %b want 010", {core_gnt, core_stall, host_rvalid}); end
        tick(); sample();
        tests++; if ({core_gnt, core_stall} !== 2'b10) begin fails++; $display("[TB] FAIL lock_exit got %b want 10", {core_gnt, core_stall}); end
        tick(); drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_lock_no_grant();
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1, 1, 8'h40, 8'(8'h11 + i), 0, 0, 8'h00, 8'h00, 1); sample();
            tests++; if ({core_gnt, core_stall, host_gnt} !== 3'b100) begin fails++; $display("[TB] FAIL nolock_c%0d got %b want 100", i, {core_gnt, core_stall, host_gnt}); end
        end
        tick(); drive(1, 0, 8'h40, 8'h00, 1, 0, 8'h01, 8'h00, 0); sample();
        tests++; if ({core_gnt, host_gnt} !== 2'b10) begin fails++; $display("[TB] FAIL nolock_still_arb got %b want 10", {core_gnt, host_gnt}); end
        tick(); drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0); sample();
        tests++; if ({core_rvalid, core_rdata} !== {1'b1, 8'h13}) begin fails++; $display("[TB] FAIL nolock_last_write got %b/%h want 1/13", core_rvalid, core_rdata); end
    endtask

    task automatic test_back_to_back();
        tick(); drive(1, 1, 8'h30, 8'h77, 0, 0, 8'h00, 8'h00, 0); sample();
        tests++; if ({core_gnt, mem_we, mem_wdata} !== {2'b11, 8'h77}) begin fails++; $display("[TB] FAIL b2b_write got %b/%b/%h want 1/1/77", core_gnt, mem_we, mem_wdata); end
        tick(); drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0); sample();
        tests++; if ({host_gnt, core_gnt, mem_addr} !== {2'b10, 8'h30}) begin fails++; $display("[TB] FAIL b2b_switch got %b/%b/%h want 1/0/30", host_gnt, core_gnt, mem_addr); end
        tick(); drive(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 0); sample();
        tests++; if ({host_rvalid, host_rdata, core_gnt} !== {1'b1, 8'h77, 1'b1}) begin fails++; $display("[TB] FAIL b2b_read_new got %b/%h/%b want 1/77/1", host_rvalid, host_rdata, core_gnt); end
        tick(); drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0); sample();
        tests++; if ({core_rvalid, core_rdata, host_rvalid} !== {1'b1, 8'h77, 1'b0}) begin fails++; $display("[TB] FAIL b2b_core_read got %b/%h/%b want 1/77/0", core_rvalid, core_rdata, host_rvalid); end
    endtask

    task automatic test_reset_mid_read();
        logic hexp;
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h03, 8'h00, 0);
        end
        tick();
        rst_n = 1'b0;
        #1;
        tests++; if ({core_rvalid, core_gnt, core_rdata} !== 10'd0) begin fails++; $display("[TB] FAIL rst_mid_drop got %b/%b/%h want 0/0/00", core_rvalid, core_gnt, core_rdata); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            sample();
            hexp = (i == 4);
            if (i == 0) begin
                tests++; if (core_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_no_rvalid got %b want 0", core_rvalid); end
            end
            tests++; if ({core_gnt, host_gnt} !== {~hexp, hexp}) begin fails++; $display("[TB] FAIL rst_starve_c%0d got %b want %b", i, {core_gnt, host_gnt}, {~hexp, hexp}); end
        end
        tick(); drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h00] = 8'hA0; mem[8'h01] = 8'hA1; mem[8'h02] = 8'hA2;
        mem[8'h03] = 8'hA3; mem[8'h10] = 8'hC3;
        test_reset();
        test_host_only();
        test_core_read();
        test_contention();
        test_lock_burst();
        test_lock_no_grant();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
